// File: rtl/ir_receiver.sv
// rtl/ir_receiver.sv - pulse-width IR frame decoder (preamble, 32 data bits MSB first, stop pulse)
module ir_receiver #(
  parameter int BASE_DELAY = 250,
  parameter int PRE_MIN    = 8,
  parameter int CNT_W      = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_port,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        rx_busy,
  output logic        rx_error
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TH_ONE    = CNT_W'(BASE_DELAY / 2);
  localparam logic [CNT_W-1:0] TH_PRE    = CNT_W'(3 * BASE_DELAY / 2);
  localparam logic [CNT_W-1:0] TH_ZERO   = CNT_W'(5 * BASE_DELAY / 2);
  localparam logic [CNT_W-1:0] TH_LONG   = CNT_W'(7 * BASE_DELAY / 2);
  localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(4 * BASE_DELAY);
  localparam logic [5:0]       PRE_NEED  = 6'(PRE_MIN);

  typedef enum logic [2:0] {C_GLITCH, C_ONE, C_PRE, C_ZERO, C_LONG} cls_e;
  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_STOP_WAIT} state_e;

  logic             sync1_q, sync2_q, line_q;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
  logic             ev_q, ev_d;
  cls_e             cls_q, cls_d;
  state_e           state_q, state_d;
  logic [5:0]       pre_cnt_q, pre_cnt_d, bit_cnt_q, bit_cnt_d;
  logic [31:0]      shift_q, shift_d, rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d, rx_error_q, rx_error_d;
  logic             rise, fall, is_bit, err;

  // line_q trails the synchronized line by one clock, so rise/fall mark its first new-level cycle
  always_comb begin
    rise     = sync2_q & ~line_q;
    fall     = ~sync2_q & line_q;
    hi_cnt_d = hi_cnt_q;
    lo_cnt_d = lo_cnt_q;
    if (sync2_q) begin
      if (rise)                     hi_cnt_d = CNT_W'(1);
      else if (hi_cnt_q != CNT_MAX) hi_cnt_d = hi_cnt_q + CNT_W'(1);
    end else begin
      if (fall)                     lo_cnt_d = CNT_W'(1);
      else if (lo_cnt_q != CNT_MAX) lo_cnt_d = lo_cnt_q + CNT_W'(1);
    end
    ev_d = fall;
    if (hi_cnt_q < TH_ONE)       cls_d = C_GLITCH;
    else if (hi_cnt_q < TH_PRE)  cls_d = C_ONE;
    else if (hi_cnt_q < TH_ZERO) cls_d = C_PRE;
    else if (hi_cnt_q < TH_LONG) cls_d = C_ZERO;
    else                         cls_d = C_LONG;
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_error_d = 1'b0;
    err        = 1'b0;
    is_bit     = (cls_q == C_ONE) || (cls_q == C_ZERO);
    if (state_q != S_IDLE && lo_cnt_d >= TIMEOUT) begin
      err = 1'b1;
    end else if (ev_q) begin
      case (state_q)
        S_IDLE: begin
          if (cls_q == C_PRE) begin
            pre_cnt_d = 6'd1;
            state_d   = S_PREAMBLE;
          end
        end
        S_PREAMBLE: begin
          if (cls_q == C_PRE) begin
            if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
          end else if (is_bit && pre_cnt_q >= PRE_NEED) begin
            shift_d   = {shift_q[30:0], cls_q == C_ONE};
            bit_cnt_d = 6'd1;
            state_d   = S_DATA;
          end else begin
            err = 1'b1;
          end
        end
        S_DATA: begin
          if (is_bit) begin
            shift_d   = {shift_q[30:0], cls_q == C_ONE};
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd31) state_d = S_STOP_WAIT;
          end else begin
            err = 1'b1;
          end
        end
        S_STOP_WAIT: begin
          if (cls_q == C_PRE) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
            shift_d    = '0;
            bit_cnt_d  = '0;
            pre_cnt_d  = '0;
          end else begin
            err = 1'b1;
          end
        end
        default: err = 1'b1;
      endcase
    end
    if (err) begin
      rx_error_d = 1'b1;
      state_d    = S_IDLE;
      shift_d    = '0;
      bit_cnt_d  = '0;
      pre_cnt_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      line_q     <= 1'b0;
      hi_cnt_q   <= '0;
      lo_cnt_q   <= '0;
      ev_q       <= 1'b0;
      cls_q      <= C_GLITCH;
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      sync1_q    <= rx_port;
      sync2_q    <= sync1_q;
      line_q     <= sync2_q;
      hi_cnt_q   <= hi_cnt_d;
      lo_cnt_q   <= lo_cnt_d;
      ev_q       <= ev_d;
      cls_q      <= cls_d;
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_error_q <= rx_error_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_error = rx_error_q;
  assign rx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_receiver.sv
// tb/tb_ir_receiver.sv - randomized self-checking bench for ir_receiver
module tb_ir_receiver;
  localparam int B      = 20;
  localparam int PMIN   = 8;
  localparam int TO     = 4 * B;
  localparam int SETTLE = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_port = 1'b0;
  logic [31:0] rx_data;
  logic        rx_valid, rx_busy, rx_error;

  ir_receiver #(.BASE_DELAY(B), .PRE_MIN(PMIN), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .rx_port(rx_port),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy), .rx_error(rx_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] obs_q[$];
  int obs_err = 0;
  int valid_cyc = -1;
  int err_cyc = -1;
  int fall_cyc = -1;

  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid || rx_error) check("excl", 32'(rx_valid & rx_error), 32'd0);
      if (rx_valid) begin
        obs_q.push_back(rx_data);
        valid_cyc = cyc;
      end
      if (rx_error) begin
        obs_err++;
        err_cyc = cyc;
      end
    end
  end

  int hi_q[$];
  int lo_q[$];
  logic [31:0] exp_q[$];
  int exp_err = 0;
  logic [31:0] exp_data = 32'd0;

  function automatic int jit(input int nom);
    return nom - 5 + int'($urandom_range(10));
  endfunction

  task automatic add_sym(input int nom);
    int h;
    h = jit(nom);
    hi_q.push_back(h);
    lo_q.push_back(h);
  endtask

  task automatic build_frame(input logic [31:0] w, input int npre, input int nbits, input bit with_stop);
    for (int i = 0; i < npre; i++) add_sym(2 * B);
    for (int i = 0; i < nbits; i++) add_sym(w[31-i] ? B : 3 * B);
    if (with_stop) add_sym(2 * B);
  endtask

  // 0 glitch, 1 one, 2 pre, 3 zero, 4 long
  function automatic int classify(input int w);
    if (2 * w < B) return 0;
    if (2 * w < 3 * B) return 1;
    if (2 * w < 5 * B) return 2;
    if (2 * w < 7 * B) return 3;
    return 4;
  endfunction

  task automatic run_model();
    bit in_frame;
    int npre, nbits, c, lo;
    logic [31:0] word;
    in_frame = 0; npre = 0; nbits = 0; word = 0;
    for (int i = 0; i < hi_q.size(); i++) begin
      c  = classify(hi_q[i]);
      lo = (i == hi_q.size() - 1) ? lo_q[i] + SETTLE : lo_q[i];
      if (!in_frame) begin
        if (c == 2) begin in_frame = 1; npre = 1; nbits = 0; word = 0; end
      end else if (nbits == 32) begin
        if (c == 2) begin exp_q.push_back(word); exp_data = word; end
        else exp_err++;
        in_frame = 0;
      end else if (c == 1 || c == 3) begin
        if (nbits == 0 && npre < PMIN) begin exp_err++; in_frame = 0; end
        else begin word = {word[30:0], c == 1}; nbits++; end
      end else if (c == 2 && nbits == 0) begin
        npre = (npre < 32) ? npre + 1 : 32;
      end else begin
        exp_err++; in_frame = 0;
      end
      if (in_frame && lo >= TO) begin exp_err++; in_frame = 0; end
    end
  endtask

  // Caller is positioned 1 time unit after a rising clock edge.
  task automatic pulse(input int hi, input int lo);
    rx_port = 1'b1;
    repeat (hi) @(posedge clock);
    #1;
    rx_port = 1'b0;
    fall_cyc = cyc;
    repeat (lo) @(posedge clock);
    #1;
  endtask

  task automatic run_scenario(input string tag);
    int n;
    obs_q.delete();
    obs_err = 0;
    exp_q.delete();
    exp_err = 0;
    run_model();
    @(posedge clock);
    #1;
    for (int i = 0; i < hi_q.size(); i++) pulse(hi_q[i], lo_q[i]);
    repeat (SETTLE) @(posedge clock);
    #1;
    check({tag, "_nvalid"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, obs_q[i], exp_q[i]);
    check({tag, "_nerr"}, 32'(obs_err), 32'(exp_err));
    check({tag, "_busy"}, 32'(rx_busy), 32'd0);
    check({tag, "_data"}, rx_data, exp_data);
    hi_q.delete();
    lo_q.delete();
  endtask

  initial begin
    int kind, npre, p;
    logic [31:0] w;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_data", rx_data, 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_error", 32'(rx_error), 32'd0);
    reset = 1'b0;

    build_frame(32'hBEEF0001, 10, 32, 1);
    run_scenario("beef");
    check("beef_const", rx_data, 32'hBEEF0001);
    check("valid_latency", 32'(valid_cyc - fall_cyc), 32'd4);

    build_frame(32'h00000000, 8, 32, 1);
    build_frame(32'hFFFFFFFF, 8, 32, 1);
    run_scenario("b2b");
    check("b2b_last", rx_data, 32'hFFFFFFFF);

    build_frame(32'h80000000, 4, 1, 0);
    run_scenario("shortpre");

    build_frame(32'hA5A5A5A5, 8, 10, 0);
    hi_q.push_back(4);
    lo_q.push_back(10);
    run_scenario("glitch");
    check("glitch_keep", rx_data, 32'hFFFFFFFF);

    build_frame(32'h3C3C3C3C, 8, 16, 0);
    lo_q[lo_q.size() - 1] = 150;
    run_scenario("timeout");
    check("timeout_at", 32'(err_cyc - fall_cyc), 32'(TO + 2));

    build_frame(32'hCAFEF00D, 8, 16, 0);
    @(posedge clock);
    #1;
    for (int i = 0; i < hi_q.size(); i++) pulse(hi_q[i], lo_q[i]);
    hi_q.delete();
    lo_q.delete();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("midrst_data", rx_data, 32'd0);
    check("midrst_valid", 32'(rx_valid), 32'd0);
    check("midrst_busy", 32'(rx_busy), 32'd0);
    check("midrst_error", 32'(rx_error), 32'd0);
    reset = 1'b0;
    exp_data = 32'd0;
    build_frame(32'h12345678, 9, 32, 1);
    run_scenario("postrst");
    check("postrst_const", rx_data, 32'h12345678);

    for (int t = 0; t < 8; t++) begin
      kind = int'($urandom_range(4));
      w    = $urandom;
      npre = PMIN + int'($urandom_range(4));
      p    = int'($urandom_range(31));
      case (kind)
        0: build_frame(w, npre, 32, 1);
        1: begin build_frame(w, npre, p, 0); hi_q.push_back(3); lo_q.push_back(10); end
        2: begin build_frame(w, npre, p, 0); hi_q.push_back(90); lo_q.push_back(90); end
        3: build_frame(w, 1 + int'($urandom_range(PMIN - 2)), 1, 0);
        default: begin
          build_frame(w, npre, p + 1, 0);
          lo_q[lo_q.size() - 1] = TO + int'($urandom_range(40));
        end
      endcase
      run_scenario($sformatf("rand%0d_k%0d", t, kind));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
